// File: rtl/game_sequencer_if.sv
// Play-sequencer bundle: frame/start/colision inputs and the strobes and levels
// consumed by the game datapath. master drives the inputs, slave is the sequencer.
interface game_sequencer_if;
  logic       frame_tick;
  logic       start;
  logic       colision;
  logic       upsig;
  logic       upsig_fast;
  logic       drop;
  logic       alive;
  logic       started;
  logic [1:0] lives;
  logic [1:0] state;

  modport master (
    output frame_tick, start, colision,
    input  upsig, upsig_fast, drop, alive, started, lives, state
  );

  modport slave (
    input  frame_tick, start, colision,
    output upsig, upsig_fast, drop, alive, started, lives, state
  );
endinterface

// File: rtl/game_sequencer.sv
// Play sequencer: IDLE/RUN/CRASH/OVER control, per-frame update strobes,
// LFSR-spaced obstacle drops and lives bookkeeping.
// Ports: clk, reset (async, active-high), bus (game_sequencer_if.slave):
//   in  frame_tick, start, colision
//   out upsig, upsig_fast, drop, alive, started, lives[1:0], state[1:0]
module game_sequencer #(
  parameter int SLOW_DIV     = 4,
  parameter int FAST_DIV     = 2,
  parameter int CRASH_FRAMES = 60,
  parameter int LIVES        = 3,
  parameter int DROP_MIN     = 4
) (
  input  logic              clk,
  input  logic              reset,
  game_sequencer_if.slave   bus
);

  localparam int SW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam int FW = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
  localparam int CW = $clog2(CRASH_FRAMES + 1);

  localparam logic [SW-1:0] SLOW_LAST  = SW'(SLOW_DIV - 1);
  localparam logic [FW-1:0] FAST_LAST  = FW'(FAST_DIV - 1);
  localparam logic [CW-1:0] CRASH_INIT = CW'(CRASH_FRAMES);
  localparam logic [CW-1:0] CRASH_ONE  = CW'(1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);
  localparam logic [4:0]    DROP_INIT  = 5'(DROP_MIN);
  localparam logic [7:0]    LFSR_SEED  = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_CRASH = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_lives, w_lives_nxt;
  logic          r_started, w_started_nxt;
  logic          r_alive;
  logic          r_upsig, w_upsig_nxt;
  logic          r_upfast, w_upfast_nxt;
  logic          r_drop, w_drop_nxt;
  logic [SW-1:0] r_slow, w_slow_nxt;
  logic [FW-1:0] r_fast, w_fast_nxt;
  logic [CW-1:0] r_crash, w_crash_nxt;
  logic [4:0]    r_drop_cnt, w_drop_cnt_nxt;
  logic [7:0]    r_lfsr, w_lfsr_nxt;
  logic [7:0]    w_lfsr_step;
  logic          w_enter_run;

  // x^8+x^6+x^5+x^4+1: maximal length, so a non-zero seed never hits 0
  assign w_lfsr_step = {r_lfsr[6:0],
                        r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  always_comb begin
    w_state_nxt    = r_state;
    w_lives_nxt    = r_lives;
    w_started_nxt  = r_started;
    w_upsig_nxt    = 1'b0;
    w_upfast_nxt   = 1'b0;
    w_drop_nxt     = 1'b0;
    w_slow_nxt     = r_slow;
    w_fast_nxt     = r_fast;
    w_crash_nxt    = r_crash;
    w_drop_cnt_nxt = r_drop_cnt;
    w_lfsr_nxt     = r_lfsr;
    w_enter_run    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt   = S_RUN;
          w_started_nxt = 1'b1;
          w_lives_nxt   = LIVES_INIT;
          w_enter_run   = 1'b1;
        end
      end
      S_RUN: begin
        // colision pre-empts a same-cycle frame_tick
        if (bus.colision) begin
          w_state_nxt = S_CRASH;
          w_crash_nxt = CRASH_INIT;
          if (r_lives != 2'd0)
            w_lives_nxt = r_lives - 2'd1;
        end else if (bus.frame_tick) begin
          if (r_slow == SLOW_LAST) begin
            w_slow_nxt  = '0;
            w_upsig_nxt = 1'b1;
            w_lfsr_nxt  = w_lfsr_step;
            if (r_drop_cnt == 5'd1) begin
              w_drop_nxt     = 1'b1;
              w_drop_cnt_nxt = DROP_INIT + {1'b0, w_lfsr_step[3:0]};
            end else begin
              w_drop_cnt_nxt = r_drop_cnt - 5'd1;
            end
          end else begin
            w_slow_nxt = r_slow + 1'b1;
          end
          if (r_fast == FAST_LAST) begin
            w_fast_nxt   = '0;
            w_upfast_nxt = 1'b1;
          end else begin
            w_fast_nxt = r_fast + 1'b1;
          end
        end
      end
      S_CRASH: begin
        if (bus.frame_tick) begin
          w_crash_nxt = r_crash - CRASH_ONE;
          if (r_crash == CRASH_ONE) begin
            if (r_lives == 2'd0) begin
              w_state_nxt = S_OVER;
            end else begin
              w_state_nxt = S_RUN;
              w_enter_run = 1'b1;
            end
          end
        end
      end
      S_OVER: begin
        if (bus.start) begin
          w_state_nxt = S_RUN;
          w_lives_nxt = LIVES_INIT;
          w_enter_run = 1'b1;
        end
      end
    endcase

    // every RUN stint starts with fresh divider and drop counters
    if (w_enter_run) begin
      w_slow_nxt     = '0;
      w_fast_nxt     = '0;
      w_drop_cnt_nxt = DROP_INIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_lives    <= LIVES_INIT;
      r_started  <= 1'b0;
      r_alive    <= 1'b0;
      r_upsig    <= 1'b0;
      r_upfast   <= 1'b0;
      r_drop     <= 1'b0;
      r_slow     <= '0;
      r_fast     <= '0;
      r_crash    <= '0;
      r_drop_cnt <= DROP_INIT;
      r_lfsr     <= LFSR_SEED;
    end else begin
      r_state    <= w_state_nxt;
      r_lives    <= w_lives_nxt;
      r_started  <= w_started_nxt;
      r_alive    <= (w_state_nxt == S_RUN);
      r_upsig    <= w_upsig_nxt;
      r_upfast   <= w_upfast_nxt;
      r_drop     <= w_drop_nxt;
      r_slow     <= w_slow_nxt;
      r_fast     <= w_fast_nxt;
      r_crash    <= w_crash_nxt;
      r_drop_cnt <= w_drop_cnt_nxt;
      r_lfsr     <= w_lfsr_nxt;
    end
  end

  assign bus.upsig      = r_upsig;
  assign bus.upsig_fast = r_upfast;
  assign bus.drop       = r_drop;
  assign bus.alive      = r_alive;
  assign bus.started    = r_started;
  assign bus.lives      = r_lives;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: cycle-level reference model feeds an expected-output
// queue; each scenario task pops and compares after every clock.
module tb_game_sequencer;

  localparam int SLOW_DIV     = 4;
  localparam int FAST_DIV     = 2;
  localparam int CRASH_FRAMES = 60;
  localparam int LIVES        = 3;
  localparam int DROP_MIN     = 4;
  localparam int FRAME_CYC    = 4;
  // {upsig,upsig_fast,drop,alive,started,lives,state}
  localparam logic [8:0] RST_VEC = {5'b00000, 2'd3, 2'd0};

  logic clk = 1'b0;
  logic reset = 1'b1;

  game_sequencer_if bus ();

  game_sequencer #(
    .SLOW_DIV(SLOW_DIV), .FAST_DIV(FAST_DIV),
    .CRASH_FRAMES(CRASH_FRAMES), .LIVES(LIVES), .DROP_MIN(DROP_MIN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];
  int obs_ups = 0;

  logic [1:0] m_state;
  logic [1:0] m_lives;
  bit         m_started;
  logic [7:0] m_lfsr;
  int         m_rt, m_ups, m_next, m_crash;

  function automatic logic [8:0] obs();
    return {bus.upsig, bus.upsig_fast, bus.drop, bus.alive,
            bus.started, bus.lives, bus.state};
  endfunction

  task automatic model_reset();
    m_state = 2'd0; m_lives = 2'(LIVES); m_started = 0;
    m_lfsr = 8'hA5; m_rt = 0; m_ups = 0; m_next = DROP_MIN; m_crash = 0;
    exp_q.delete();
  endtask

  task automatic enter_run();
    m_state = 2'd1; m_rt = 0; m_ups = 0; m_next = DROP_MIN;
  endtask

  // drive one cycle, push the model's prediction of the registered outputs
  task automatic step(input bit t, input bit c, input bit s);
    bit up, fu, dr;
    bus.frame_tick = t; bus.colision = c; bus.start = s;
    up = 0; fu = 0; dr = 0;
    case (m_state)
      2'd0: if (s) begin enter_run(); m_started = 1; m_lives = 2'(LIVES); end
      2'd1: begin
        if (c) begin
          m_state = 2'd2; m_crash = CRASH_FRAMES;
          if (m_lives != 0) m_lives = m_lives - 2'd1;
        end else if (t) begin
          m_rt++;
          if (m_rt % SLOW_DIV == 0) begin
            up = 1; m_ups++;
            m_lfsr = {m_lfsr[6:0], m_lfsr[7]^m_lfsr[5]^m_lfsr[4]^m_lfsr[3]};
            if (m_ups == m_next) begin
              dr = 1; m_next = m_next + DROP_MIN + int'(m_lfsr[3:0]);
            end
          end
          if (m_rt % FAST_DIV == 0) fu = 1;
        end
      end
      2'd2: if (t) begin
        m_crash--;
        if (m_crash == 0) begin
          if (m_lives == 0) m_state = 2'd3;
          else enter_run();
        end
      end
      default: if (s) begin enter_run(); m_lives = 2'(LIVES); end
    endcase
    exp_q.push_back({up, fu, dr, m_state == 2'd1, m_started, m_lives, m_state});
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    bus.frame_tick = 0; bus.start = 0; bus.colision = 0;
    reset = 1; model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== RST_VEC) begin
      failures++; $display("FAIL reset_vals: got %b expected %b", obs(), RST_VEC);
    end
    reset = 0;
    for (int f = 0; f < 10; f++)
      for (int k = 0; k < FRAME_CYC; k++) begin
        step(k == 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin
          failures++; $display("FAIL idle f%0d k%0d: got %b expected %b", f, k, obs(), e);
        end
      end
    checks++;
    if (bus.state !== 2'd0 || bus.started !== 1'b0) begin
      failures++; $display("FAIL idle_end: got st=%0d started=%b expected 0/0", bus.state, bus.started);
    end
  endtask

  task automatic test_start_strobes();
    logic [8:0] e;
    int n_up, n_fu;
    n_up = 0; n_fu = 0;
    step(0, 0, 1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      failures++; $display("FAIL start: got %b expected %b", obs(), e);
    end
    for (int f = 0; f < 8; f++)
      for (int k = 0; k < FRAME_CYC; k++) begin
        step(k == 0, 0, 0);
        if (bus.upsig) begin n_up++; obs_ups++; end
        if (bus.upsig_fast) n_fu++;
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin
          failures++; $display("FAIL run8 f%0d k%0d: got %b expected %b", f, k, obs(), e);
        end
      end
    checks++;
    if (n_up != 2 || n_fu != 4) begin
      failures++; $display("FAIL strobe_count: got up=%0d fast=%0d expected 2/4", n_up, n_fu);
    end
    checks++;
    if (bus.started !== 1'b1 || bus.alive !== 1'b1) begin
      failures++; $display("FAIL run_levels: got started=%b alive=%b expected 1/1", bus.started, bus.alive);
    end
  endtask

  task automatic test_drops();
    logic [8:0] e;
    int n_drop, first_at;
    n_drop = 0; first_at = -1;
    for (int f = 0; f < 200; f++)
      for (int k = 0; k < FRAME_CYC; k++) begin
        step(k == 0, 0, 0);
        if (bus.upsig) obs_ups++;
        if (bus.drop) begin
          n_drop++;
          if (first_at < 0) first_at = obs_ups;
        end
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin
          failures++; $display("FAIL drops f%0d k%0d: got %b expected %b", f, k, obs(), e);
        end
      end
    checks++;
    if (first_at != 4) begin
      failures++; $display("FAIL first_drop: got upsig#%0d expected 4", first_at);
    end
    checks++;
    if (n_drop < 3) begin
      failures++; $display("FAIL drop_count: got %0d expected at least 3", n_drop);
    end
  endtask

  task automatic test_crash();
    logic [8:0] e;
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < FRAME_CYC; k++) begin
        step(k == 0, (f == 3 && k == 0), 0);
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin
          failures++; $display("FAIL precrash f%0d k%0d: got %b expected %b", f, k, obs(), e);
        end
        if (f == 3 && k == 0) begin
          checks++;
          if (bus.upsig !== 1'b0 || bus.state !== 2'd2 || bus.lives !== 2'd2) begin
            failures++;
            $display("FAIL crash_entry: got up=%b st=%0d lives=%0d expected 0/2/2",
                     bus.upsig, bus.state, bus.lives);
          end
        end
      end
    for (int f = 0; f < CRASH_FRAMES; f++)
      for (int k = 0; k < FRAME_CYC; k++) begin
        step(k == 0, (f >= 10 && f <= 12), 0);
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin
          failures++; $display("FAIL crash f%0d k%0d: got %b expected %b", f, k, obs(), e);
        end
        if (f == CRASH_FRAMES - 2 && k == FRAME_CYC - 1) begin
          checks++;
          if (bus.state !== 2'd2) begin
            failures++; $display("FAIL crash_hold: got st=%0d expected 2", bus.state);
          end
        end
      end
    checks++;
    if (bus.state !== 2'd1 || bus.alive !== 1'b1) begin
      failures++; $display("FAIL crash_resume: got st=%0d alive=%b expected 1/1", bus.state, bus.alive);
    end
  endtask

  task automatic test_game_over();
    logic [8:0] e;
    for (int n = 0; n < 2; n++) begin
      step(0, 1, 0);
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
        failures++; $display("FAIL over_hit%0d: got %b expected %b", n, obs(), e);
      end
      for (int f = 0; f < CRASH_FRAMES; f++)
        for (int k = 0; k < FRAME_CYC; k++) begin
          step(k == 0, 0, 0);
          e = exp_q.pop_front(); checks++;
          if (obs() !== e) begin
            failures++; $display("FAIL over_crash%0d f%0d: got %b expected %b", n, f, obs(), e);
          end
        end
    end
    checks++;
    if (bus.state !== 2'd3 || bus.lives !== 2'd0 || bus.alive !== 1'b0) begin
      failures++;
      $display("FAIL over_state: got st=%0d lives=%0d alive=%b expected 3/0/0",
               bus.state, bus.lives, bus.alive);
    end
    for (int f = 0; f < 5; f++)
      for (int k = 0; k < FRAME_CYC; k++) begin
        step(k == 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin
          failures++; $display("FAIL over_idle f%0d: got %b expected %b", f, obs(), e);
        end
      end
    step(0, 0, 1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      failures++; $display("FAIL restart: got %b expected %b", obs(), e);
    end
    checks++;
    if (bus.state !== 2'd1 || bus.lives !== 2'd3 || bus.started !== 1'b1) begin
      failures++;
      $display("FAIL restart_vals: got st=%0d lives=%0d started=%b expected 1/3/1",
               bus.state, bus.lives, bus.started);
    end
  endtask

  task automatic test_reset_mid_crash();
    logic [8:0] e;
    step(0, 1, 0);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      failures++; $display("FAIL mid_hit: got %b expected %b", obs(), e);
    end
    for (int f = 0; f < 30; f++)
      for (int k = 0; k < FRAME_CYC; k++) begin
        step(k == 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin
          failures++; $display("FAIL mid_crash f%0d: got %b expected %b", f, obs(), e);
        end
      end
    reset = 1;
    #1;
    checks++;
    if (obs() !== RST_VEC) begin
      failures++; $display("FAIL async_reset: got %b expected %b", obs(), RST_VEC);
    end
    model_reset();
    #4;
    reset = 0;
    step(0, 0, 1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      failures++; $display("FAIL post_reset_start: got %b expected %b", obs(), e);
    end
    for (int f = 0; f < 8; f++)
      for (int k = 0; k < FRAME_CYC; k++) begin
        step(k == 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin
          failures++; $display("FAIL post_reset f%0d k%0d: got %b expected %b", f, k, obs(), e);
        end
      end
  endtask

  initial begin
    test_reset();
    test_start_strobes();
    test_drops();
    test_crash();
    test_game_over();
    test_reset_mid_crash();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
